// File: rtl/cnt1_vec_arbiter.sv
// cnt1_vec_arbiter: round-robin front end that shares one cnt1 popcount
// pipeline between NUM_REQ sub-vector streams. A grant covers a whole vector
// (SUB_VECTOR_NO beats). The granted id goes into a tag FIFO and is paired
// with the count when cnt1 reports it.
// Optional feature macro: CNT1_ARB_STATS_EN builds per-requester saturating
// granted-vector counters on stat_VecCnt; otherwise stat_VecCnt is tied to 0.

`ifdef CNT1_ARB_STATS_EN
// Per-requester 16-bit saturating grant counter.
module cnt1_arb_stat_ctr (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q;

  // count grants, hold at all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          cnt_q <= '0;
    else if (inc_i && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

module cnt1_vec_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int VECTOR_WIDTH  = 920,
  parameter int BUS_WIDTH     = 128,
  parameter int SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  parameter int CNT_WIDTH     = $clog2(VECTOR_WIDTH),
  parameter int ID_WIDTH      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TAG_DEPTH     = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_Vector,
  input  logic [NUM_REQ-1:0]             req_Valid,
  input  logic [NUM_REQ-1:0]             req_Last,
  output logic [NUM_REQ-1:0]             req_Ready,
  output logic [BUS_WIDTH-1:0]           cnt_Vector,
  output logic                           cnt_Valid,
  output logic                           cnt_Last,
  input  logic                           cnt_Ready,
  input  logic                           mon_CntNew,
  input  logic                           mon_Ready,
  input  logic [CNT_WIDTH-1:0]           mon_Cnt,
  output logic                           res_Valid,
  output logic [CNT_WIDTH-1:0]           res_Cnt,
  output logic [ID_WIDTH-1:0]            res_Id,
  output logic                           err_TagUnderflow,
  output logic [NUM_REQ*16-1:0]          stat_VecCnt
);
  localparam int BEAT_W = $clog2(SUB_VECTOR_NO) + 1;
  localparam int AW     = $clog2(TAG_DEPTH);
  localparam int PW     = AW + 1;
  localparam int ID_W1  = ID_WIDTH + 1;
  localparam logic [ID_W1-1:0]    NREQ_W    = ID_W1'(NUM_REQ);
  localparam logic [BEAT_W-1:0]   BEAT_LAST = BEAT_W'(SUB_VECTOR_NO - 1);
  localparam logic [ID_WIDTH-1:0] ID_LAST   = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]   rr_q, rr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [ID_WIDTH-1:0]   tag_q [TAG_DEPTH];
  logic                  res_vld_q;
  logic [CNT_WIDTH-1:0]  res_cnt_q;
  logic [ID_WIDTH-1:0]   res_id_q;
  logic                  err_q;

  logic                  arb_vld;
  logic [ID_WIDTH-1:0]   arb_id, cand_id;
  logic [ID_W1-1:0]      cand_sum;
  logic                  push, pop, pop_ok;
  logic                  fifo_empty, fifo_full;

  // occupancy flags from pointers with a wrap bit
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = mon_CntNew && mon_Ready;
  assign pop_ok     = pop && !fifo_empty;

  // round-robin pick: first valid requester at or after rr_q (descending scan, last hit wins)
  always_comb begin
    arb_vld  = 1'b0;
    arb_id   = '0;
    cand_sum = '0;
    cand_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_q} + ID_W1'(k);
      cand_id  = (cand_sum >= NREQ_W) ? ID_WIDTH'(cand_sum - NREQ_W) : ID_WIDTH'(cand_sum);
      if (req_Valid[cand_id]) begin
        arb_vld = 1'b1;
        arb_id  = cand_id;
      end
    end
  end

  // grant FSM next state and beat routing; IDLE inserts one bubble between bursts
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    push       = 1'b0;
    cnt_Vector = '0;
    cnt_Valid  = 1'b0;
    cnt_Last   = 1'b0;
    req_Ready  = '0;
    case (state_q)
      IDLE: begin
        // full is judged on pre-pop occupancy
        if (arb_vld && !fifo_full) begin
          gnt_d   = arb_id;
          push    = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        cnt_Vector       = req_Vector[gnt_q*BUS_WIDTH +: BUS_WIDTH];
        cnt_Valid        = req_Valid[gnt_q];
        cnt_Last         = req_Last[gnt_q];
        req_Ready[gnt_q] = cnt_Ready;
        if (cnt_Valid && cnt_Ready) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            rr_d    = (gnt_q == ID_LAST) ? '0 : gnt_q + ID_WIDTH'(1);
            state_d = IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant, round-robin pointer and beat counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  // tag FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + PW'(push);
      rptr_q <= rptr_q + PW'(pop_ok);
    end
  end

  // tag storage; contents are don't-care while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (push) tag_q[wptr_q[AW-1:0]] <= arb_id;
  end

  // result pairing: pulse valid one cycle after a pop, hold count/id until next pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_vld_q <= 1'b0;
      res_cnt_q <= '0;
      res_id_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      if (pop_ok) begin
        res_vld_q <= 1'b1;
        res_cnt_q <= mon_Cnt;
        res_id_q  <= tag_q[rptr_q[AW-1:0]];
      end else if (pop) begin
        err_q <= 1'b1;
      end
    end
  end

  assign res_Valid        = res_vld_q;
  assign res_Cnt          = res_cnt_q;
  assign res_Id           = res_id_q;
  assign err_TagUnderflow = err_q;

`ifdef CNT1_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    cnt1_arb_stat_ctr u_ctr (
      .clk   (clk),
      .rstn  (rstn),
      .inc_i (push && (arb_id == ID_WIDTH'(i))),
      .cnt_o (stat_VecCnt[i*16 +: 16])
    );
  end
`else
  assign stat_VecCnt = '0;
`endif

endmodule

// File: tb/tb_cnt1_vec_arbiter.sv
// Scoreboard bench for cnt1_vec_arbiter (default parameters: 2 requesters,
// 8 beats per vector, 8-deep tag FIFO). Stimulus pushes expected beats and
// results into queues; a separate monitor pops and compares them.
module tb_cnt1_vec_arbiter;
  localparam int NR = 2, BW = 128, CW = 10, IW = 1, SUB = 8;

  typedef struct packed { logic [BW-1:0] d; logic l; } beat_t;
  typedef struct packed { logic [CW-1:0] c; logic [IW-1:0] id; } res_t;

  logic             clk = 1'b0, rstn = 1'b0;
  logic [NR*BW-1:0] req_Vector;
  logic [NR-1:0]    req_Valid, req_Last, req_Ready;
  logic [BW-1:0]    cnt_Vector;
  logic             cnt_Valid, cnt_Last, cnt_Ready;
  logic             mon_CntNew, mon_Ready;
  logic [CW-1:0]    mon_Cnt;
  logic             res_Valid;
  logic [CW-1:0]    res_Cnt;
  logic [IW-1:0]    res_Id;
  logic             err_TagUnderflow;
  logic [NR*16-1:0] stat_VecCnt;

  int    checks = 0, failures = 0;
  beat_t src0[$], src1[$], exp_q[$];
  res_t  exp_res[$];
  logic  nxt_cr = 1'b1, nxt_new = 1'b0, nxt_mr = 1'b1;
  logic [CW-1:0] nxt_cnt = '0;
  logic [NR-1:0] fire = '0;

  cnt1_vec_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req_Vector(req_Vector), .req_Valid(req_Valid), .req_Last(req_Last), .req_Ready(req_Ready),
    .cnt_Vector(cnt_Vector), .cnt_Valid(cnt_Valid), .cnt_Last(cnt_Last), .cnt_Ready(cnt_Ready),
    .mon_CntNew(mon_CntNew), .mon_Ready(mon_Ready), .mon_Cnt(mon_Cnt),
    .res_Valid(res_Valid), .res_Cnt(res_Cnt), .res_Id(res_Id),
    .err_TagUnderflow(err_TagUnderflow), .stat_VecCnt(stat_VecCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(int r, int v, int b);
    beat_t t;
    t.d = {4{8'(r), 8'(v), 8'(b), 8'hC3}};
    t.l = (b == SUB - 1);
    return t;
  endfunction

  // queue one vector on requester r; expect its first nexp beats on cnt_*
  task automatic load(int r, int v, int nexp);
    for (int b = 0; b < SUB; b++) begin
      if (r == 0) src0.push_back(mk(r, v, b));
      else        src1.push_back(mk(r, v, b));
      if (b < nexp) exp_q.push_back(mk(r, v, b));
    end
  endtask

  // one clock: retire last handshakes, drive inputs at negedge, latch handshakes
  task automatic cycle();
    @(negedge clk);
    if (fire[0] && src0.size() > 0) void'(src0.pop_front());
    if (fire[1] && src1.size() > 0) void'(src1.pop_front());
    fire = '0;
    req_Valid[0]         = (src0.size() > 0);
    req_Valid[1]         = (src1.size() > 0);
    req_Vector[0 +: BW]  = (src0.size() > 0) ? src0[0].d : {BW{1'b0}};
    req_Vector[BW +: BW] = (src1.size() > 0) ? src1[0].d : {BW{1'b0}};
    req_Last[0]          = (src0.size() > 0) ? src0[0].l : 1'b0;
    req_Last[1]          = (src1.size() > 0) ? src1[0].l : 1'b0;
    cnt_Ready  = nxt_cr;
    mon_CntNew = nxt_new;
    mon_Ready  = nxt_mr;
    mon_Cnt    = nxt_cnt;
    #1;
    fire = req_Valid & req_Ready;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic drain(string name, int max);
    int n = 0;
    while ((exp_q.size() > 0 || src0.size() > 0 || src1.size() > 0) && n < max) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s timeout beats_left=%0d required=0", name, exp_q.size());
    end
    run(2);
  endtask

  task automatic wait_burst(string name);
    int n = 0;
    while (!cnt_Valid && n < 20) begin
      cycle();
      n++;
    end
    chk(name, cnt_Valid, 1'b1);
  endtask

  task automatic pop_res(int c, int id);
    res_t r;
    r.c  = CW'(c);
    r.id = IW'(id);
    exp_res.push_back(r);
    nxt_new = 1'b1;
    nxt_cnt = CW'(c);
    cycle();
    nxt_new = 1'b0;
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1 rstn = 1'b1;
    fire = '0;
  endtask

  // monitor: compare every accepted beat and every result pulse with the scoreboard
  initial begin : mon
    beat_t e;
    res_t  r;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && cnt_Valid && cnt_Ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL beat_unexpected actual=%0h required=none", cnt_Vector);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", cnt_Vector, e.d);
          chk("beat_last", cnt_Last, e.l);
        end
      end
      if (res_Valid) begin
        if (exp_res.size() == 0) begin
          checks++; failures++;
          $display("FAIL res_unexpected actual_cnt=%0d actual_id=%0d required=none", res_Cnt, res_Id);
        end else begin
          r = exp_res.pop_front();
          chk("res_cnt", res_Cnt, r.c);
          chk("res_id", res_Id, r.id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_Valid = '0; req_Vector = '0; req_Last = '0;
    cnt_Ready = 1'b1; mon_CntNew = 1'b0; mon_Ready = 1'b1; mon_Cnt = '0;
    #12;
    chk("rst_req_ready", req_Ready, 2'b00);
    chk("rst_cnt_valid", cnt_Valid, 1'b0);
    chk("rst_res_valid", res_Valid, 1'b0);
    chk("rst_res_cnt", res_Cnt, 10'd0);
    chk("rst_res_id", res_Id, 1'b0);
    chk("rst_err", err_TagUnderflow, 1'b0);
    chk("rst_stat", stat_VecCnt, 32'd0);
    @(negedge clk);
    #3 rstn = 1'b1;

    // single requester, grant one cycle after valid
    load(0, 1, SUB);
    cycle();
    chk("t1_no_grant_yet", cnt_Valid, 1'b0);
    cycle();
    chk("t1_grant_valid", cnt_Valid, 1'b1);
    chk("t1_grant_ready", req_Ready, 2'b01);
    drain("t1_drain", 40);
    nxt_new = 1'b1; nxt_mr = 1'b0;
    cycle();
    nxt_new = 1'b0; nxt_mr = 1'b1;
    cycle();
    chk("t1_no_pop_without_ready", res_Valid, 1'b0);
    pop_res(123, 0);
    run(3);
    chk("t1_res_cnt_hold", res_Cnt, 10'd123);
    chk("t1_res_id_hold", res_Id, 1'b0);

    // both requesters continuously valid: 0,1,0,1 whole vectors
    do_reset();
    load(0, 2, SUB); load(1, 3, SUB); load(0, 4, SUB); load(1, 5, SUB);
    drain("t2_drain", 80);
    pop_res(1, 0); pop_res(2, 1); pop_res(3, 0); pop_res(4, 1);
    run(3);

    // cnt_Ready stall mid-burst
    load(1, 6, SUB);
    wait_burst("t3_burst");
    for (int i = 0; i < 2; i++) cycle();
    nxt_cr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_stall_ready", req_Ready, 2'b00);
      chk("t3_stall_valid", cnt_Valid, 1'b1);
    end
    nxt_cr = 1'b1;
    drain("t3_drain", 40);
    pop_res(55, 1);
    run(3);

    // tag FIFO full with no pops: 8 grants, 9th blocked until a pop
    for (int v = 10; v < 19; v++) load(0, v, SUB);
    run(85);
    chk("t4_beats_pending", exp_q.size(), 8);
    chk("t4_src_pending", src0.size(), 8);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t4_full_ready", req_Ready, 2'b00);
      chk("t4_full_valid", cnt_Valid, 1'b0);
    end
    pop_res(7, 0);
    drain("t4_drain", 30);
    for (int k = 0; k < 8; k++) pop_res(8 + k, 0);
    run(3);

    // pop with empty FIFO: no result, sticky error
    nxt_new = 1'b1; nxt_cnt = 10'd99;
    cycle();
    nxt_new = 1'b0;
    cycle();
    chk("t5_err_set", err_TagUnderflow, 1'b1);
    chk("t5_no_res", res_Valid, 1'b0);
    run(3);
    chk("t5_err_sticky", err_TagUnderflow, 1'b1);
    chk("t5_res_cnt_hold", res_Cnt, 10'd15);
`ifdef CNT1_ARB_STATS_EN
    chk("t5_stat", stat_VecCnt, {16'd3, 16'd11});
`else
    chk("t5_stat", stat_VecCnt, 32'd0);
`endif

    // reset mid-burst at beat 3: FIFO and pointer cleared, next grant to req0
    do_reset();
    chk("t6_err_clear", err_TagUnderflow, 1'b0);
    chk("t6_res_cnt_clear", res_Cnt, 10'd0);
    load(0, 20, SUB);
    drain("t6_prep", 40);
    pop_res(1, 0);
    run(2);
    nxt_cr = 1'b0;
    load(1, 21, 3);
    load(0, 22, SUB);
    wait_burst("t6_burst");
    nxt_cr = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    nxt_cr = 1'b0;
    cycle();
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_valid", cnt_Valid, 1'b0);
    chk("t6_async_ready", req_Ready, 2'b00);
    rstn = 1'b1;
    fire = '0;
    src1.delete();
    load(1, 23, SUB);
    nxt_cr = 1'b1;
    drain("t6_drain", 40);
    pop_res(2, 0);
    pop_res(3, 1);
    run(3);
`ifdef CNT1_ARB_STATS_EN
    chk("t6_stat", stat_VecCnt, {16'd1, 16'd1});
`else
    chk("t6_stat", stat_VecCnt, 32'd0);
`endif

    chk("end_beats_left", exp_q.size(), 0);
    chk("end_res_left", exp_res.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
